// File: rtl/wb_pkg.sv
// Shared Wishbone bridge types: FSM states, request/response records, width constants.
package wb_pkg;

  localparam int unsigned WB_ADR_WIDTH = 32;
  localparam int unsigned WB_DAT_WIDTH = 32;
  localparam int unsigned WB_SEL_WIDTH = WB_DAT_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } wb_bridge_state_t;

  typedef struct packed {
    logic                    we;
    logic [WB_ADR_WIDTH-1:0] adr;
    logic [WB_DAT_WIDTH-1:0] dat;
    logic [WB_SEL_WIDTH-1:0] sel;
  } wb_req_t;

  typedef struct packed {
    logic [WB_DAT_WIDTH-1:0] dat;
    logic                    err;
  } wb_resp_t;

  // A zero limit still needs a 1-bit register to stay legal.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter with clear/enable; expired flags the limit-th enabled cycle.
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int unsigned limit = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = cnt_width(limit);
  localparam logic [CW-1:0] LIM    = CW'(limit);
  localparam logic [CW-1:0] LIM_M1 = CW'(limit - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIM)) begin
      count <= count + CW'(1);
    end
  end

  // Fires during the cycle whose closing edge brings the count to the limit.
  always_comb begin
    expired = 1'b0;
    if ((limit != 0) && enable && (count >= LIM_M1)) begin
      expired = 1'b1;
    end
  end

endmodule

// File: rtl/wb_master_bridge.sv
// Ready/valid core channel to single-outstanding Wishbone classic master with bus timeout.
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int unsigned adr_width      = WB_ADR_WIDTH,
  parameter int unsigned dat_width      = WB_DAT_WIDTH,
  parameter int unsigned sel_width      = dat_width / 8,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [adr_width-1:0] req_adr,
  input  logic [dat_width-1:0] req_dat,
  input  logic [sel_width-1:0] req_sel,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [dat_width-1:0] resp_dat,
  output logic                 resp_err,
  output logic                 wb_cyc,
  output logic                 wb_stb,
  output logic                 wb_we,
  output logic [adr_width-1:0] wb_adr,
  output logic [dat_width-1:0] wb_datwr,
  output logic [sel_width-1:0] wb_sel,
  input  logic [dat_width-1:0] wb_datrd,
  input  logic                 wb_ack
);

  wb_bridge_state_t state, state_next;
  logic accept, done_ack, done_to, resp_take, expired;

  wb_timeout_counter #(
    .limit(timeout_cycles)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (state != BUS),
    .enable (state == BUS),
    .expired(expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    resp_take  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (wb_ack) begin
          done_ack   = 1'b1;
          state_next = RESP;
        end else if (expired) begin
          done_to    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_take  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_datwr <= '0;
      wb_sel   <= '0;
      resp_dat <= '0;
      resp_err <= 1'b0;
    end else if (accept) begin
      wb_cyc   <= 1'b1;
      wb_stb   <= 1'b1;
      wb_we    <= req_we;
      wb_adr   <= req_adr;
      wb_datwr <= req_we ? req_dat : '0;
      wb_sel   <= req_we ? req_sel : '1;
    end else if (done_ack || done_to) begin
      wb_cyc   <= 1'b0;
      wb_stb   <= 1'b0;
      wb_we    <= 1'b0;
      wb_adr   <= '0;
      wb_datwr <= '0;
      wb_sel   <= '0;
      resp_dat <= (done_ack && !wb_we) ? wb_datrd : '0;
      resp_err <= done_to;
    end else if (resp_take) begin
      resp_dat <= '0;
      resp_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge with a scripted Wishbone slave and timeout of 8.
module tb_wb_master_bridge;
  import wb_pkg::*;

  localparam int unsigned T = 8;

  logic                    clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    req_valid = 1'b0;
  logic                    req_ready;
  logic                    req_we = 1'b0;
  logic [WB_ADR_WIDTH-1:0] req_adr = '0;
  logic [WB_DAT_WIDTH-1:0] req_dat = '0;
  logic [WB_SEL_WIDTH-1:0] req_sel = '0;
  logic                    resp_valid;
  logic                    resp_ready = 1'b0;
  logic [WB_DAT_WIDTH-1:0] resp_dat;
  logic                    resp_err;
  logic                    wb_cyc, wb_stb, wb_we;
  logic [WB_ADR_WIDTH-1:0] wb_adr;
  logic [WB_DAT_WIDTH-1:0] wb_datwr;
  logic [WB_SEL_WIDTH-1:0] wb_sel;
  logic [WB_DAT_WIDTH-1:0] wb_datrd = '0;
  logic                    wb_ack = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_bad    = 0;
  wb_resp_t    exp_q[$];

  wb_master_bridge #(
    .adr_width     (WB_ADR_WIDTH),
    .dat_width     (WB_DAT_WIDTH),
    .sel_width     (WB_SEL_WIDTH),
    .timeout_cycles(T)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .req_sel   (req_sel),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_dat  (resp_dat),
    .resp_err  (resp_err),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_datwr  (wb_datwr),
    .wb_sel    (wb_sel),
    .wb_datrd  (wb_datrd),
    .wb_ack    (wb_ack)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ack_on: BUS cycle (1-based) in which the slave acks; 0 means never.
  task automatic do_txn(input logic we, input logic [WB_ADR_WIDTH-1:0] adr,
                        input logic [WB_DAT_WIDTH-1:0] dat, input logic [WB_SEL_WIDTH-1:0] sel,
                        input int unsigned ack_on, input logic [WB_DAT_WIDTH-1:0] rdata,
                        input int unsigned hold);
    logic [WB_SEL_WIDTH-1:0] exp_sel;
    logic [WB_DAT_WIDTH-1:0] exp_wdat;
    int unsigned             cyc_cnt, exp_cnt, waited;
    logic                    ack_in_time;
    wb_resp_t                exp_r, got_r;

    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    check_eq("req_ready_before_req", 64'(req_ready), 64'd1);

    ack_in_time = (ack_on >= 1) && (ack_on <= T);
    exp_cnt     = ack_in_time ? ack_on : T;
    exp_sel     = we ? sel : '1;
    exp_wdat    = we ? dat : '0;
    exp_r.err   = !ack_in_time;
    exp_r.dat   = (ack_in_time && !we) ? rdata : '0;
    exp_q.push_back(exp_r);

    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    @(negedge clock);
    req_valid = 1'b0; req_we = ~we; req_adr = ~adr; req_dat = ~dat; req_sel = ~sel;
    check_eq("cyc_latency", 64'(wb_cyc), 64'd1);

    cyc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!wb_cyc) break;
      cyc_cnt++;
      check_eq("stb", 64'(wb_stb), 64'd1);
      check_eq("we", 64'(wb_we), 64'(we));
      check_eq("adr", 64'(wb_adr), 64'(adr));
      check_eq("sel", 64'(wb_sel), 64'(exp_sel));
      check_eq("datwr", 64'(wb_datwr), 64'(exp_wdat));
      check_eq("req_ready_bus", 64'(req_ready), 64'd0);
      wb_ack   = (cyc_cnt == ack_on);
      wb_datrd = (cyc_cnt == ack_on) ? rdata : $urandom;
      @(negedge clock);
    end
    wb_ack = 1'b0;
    check_eq("cyc_cycles", 64'(cyc_cnt), 64'(exp_cnt));
    check_eq("resp_latency", 64'(resp_valid), 64'd1);
    check_eq("sel_cleared", 64'(wb_sel), 64'd0);
    check_eq("adr_cleared", 64'(wb_adr), 64'd0);

    for (int h = 0; h < int'(hold); h++) begin
      req_valid = 1'b1;
      check_eq("hold_valid", 64'(resp_valid), 64'd1);
      check_eq("hold_ready", 64'(req_ready), 64'd0);
      check_eq("hold_dat", 64'(resp_dat), 64'(exp_r.dat));
      check_eq("hold_err", 64'(resp_err), 64'(exp_r.err));
      @(negedge clock);
      check_eq("hold_no_cyc", 64'(wb_cyc), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check_eq("resp_valid_at_take", 64'(resp_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got_r.dat = resp_dat;
      got_r.err = resp_err;
      exp_r = exp_q.pop_front();
      check_eq("resp_dat", 64'(got_r.dat), 64'(exp_r.dat));
      check_eq("resp_err", 64'(got_r.err), 64'(exp_r.err));
    end
    @(negedge clock);
    resp_ready = 1'b0;
    check_eq("resp_dropped", 64'(resp_valid), 64'd0);
    check_eq("req_ready_after", 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    check_eq("rst_cyc", 64'(wb_cyc), 64'd0);
    check_eq("rst_sel", 64'(wb_sel), 64'd0);
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_dat", 64'(resp_dat), 64'd0);
    check_eq("rst_resp_err", 64'(resp_err), 64'd0);
    check_eq("rst_req_ready", 64'(req_ready), 64'd1);
    reset = 1'b0;
    @(negedge clock);

    wb_ack = 1'b1;
    @(negedge clock);
    wb_ack = 1'b0;
    check_eq("spurious_ack_resp", 64'(resp_valid), 64'd0);
    check_eq("spurious_ack_ready", 64'(req_ready), 64'd1);

    do_txn(1'b0, 32'h100, 32'h0, 4'h0, 2, 32'hDEADBEEF, 0);
    do_txn(1'b1, 32'h204, 32'h12345678, 4'h3, 1, 32'hCAFEF00D, 0);
    do_txn(1'b0, 32'h300, 32'h0, 4'h0, 0, 32'h11111111, 0);
    do_txn(1'b0, 32'h304, 32'h0, 4'h0, T, 32'hA5A5_5A5A, 0);
    do_txn(1'b0, 32'h308, 32'h0, 4'h0, T + 1, 32'h2222_3333, 0);
    do_txn(1'b1, 32'h40C, 32'hFEED_BEEF, 4'hF, 5, 32'h0BAD_0BAD, 5);
    do_txn(1'b0, 32'h410, 32'h0, 4'h0, 1, 32'h0123_4567, 3);

    // Reset in the middle of a bus cycle.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h500;
    @(negedge clock);
    req_valid = 1'b0;
    check_eq("mid_cyc_up", 64'(wb_cyc), 64'd1);
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("mid_rst_cyc", 64'(wb_cyc), 64'd0);
    check_eq("mid_rst_stb", 64'(wb_stb), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_eq("post_rst_no_resp", 64'(resp_valid), 64'd0);
    end
    check_eq("post_rst_ready", 64'(req_ready), 64'd1);
    do_txn(1'b0, 32'h600, 32'h0, 4'h0, 3, 32'h7777_8888, 1);

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
